// File: rtl/rtype_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtype_pkg
//  Description : Shared definitions for the R-type issue controller:
//                instruction field layout, LOADI opcode, FSM state
//                encoding and the decoded-instruction struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtype_pkg;

    // Instruction word layout: [31:27] op, [26:23] rs, [22:19] rt,
    // [18:15] rd, [14:0] imm
    localparam int c_OP_LSB  = 27;
    localparam int c_OP_W    = 5;
    localparam int c_RS_LSB  = 23;
    localparam int c_RT_LSB  = 19;
    localparam int c_RD_LSB  = 15;
    localparam int c_REG_W   = 4;
    localparam int c_IMM_LSB = 0;
    localparam int c_IMM_W   = 15;

    // Load-immediate pseudo-op; sits above the legal ALU opcode range
    localparam logic [c_OP_W-1:0] c_OP_LOADI = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } rtype_state_e;

    typedef struct packed {
        logic [c_OP_W-1:0]  op;
        logic [c_REG_W-1:0] rs;
        logic [c_REG_W-1:0] rt;
        logic [c_REG_W-1:0] rd;
        logic [c_IMM_W-1:0] imm;
    } rtype_instr_t;

endpackage
`default_nettype wire

// File: rtl/rtype_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rtype_instr_decode
//  Description : Combinational decode of a packed R-type instruction word
//                into register/opcode fields, sign-extended immediate and
//                LOADI / illegal-opcode flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtype_instr_decode
    import rtype_pkg::*;
#(
    parameter int DW      = 32,
    parameter int NUM_OPS = 8
) (
    input  logic [31:0]        instr,
    output logic [c_OP_W-1:0]  op,
    output logic [c_REG_W-1:0] rs,
    output logic [c_REG_W-1:0] rt,
    output logic [c_REG_W-1:0] rd,
    output logic [DW-1:0]      imm_sext,
    output logic               is_loadi,
    output logic               is_illegal
);

    rtype_instr_t w_fields;

    assign w_fields.op  = instr[c_OP_LSB  +: c_OP_W];
    assign w_fields.rs  = instr[c_RS_LSB  +: c_REG_W];
    assign w_fields.rt  = instr[c_RT_LSB  +: c_REG_W];
    assign w_fields.rd  = instr[c_RD_LSB  +: c_REG_W];
    assign w_fields.imm = instr[c_IMM_LSB +: c_IMM_W];

    assign op = w_fields.op;
    assign rs = w_fields.rs;
    assign rt = w_fields.rt;
    assign rd = w_fields.rd;

    assign imm_sext = {{(DW-c_IMM_W){w_fields.imm[c_IMM_W-1]}}, w_fields.imm};

    // LOADI is outside the ALU range but legal; everything else at or above
    // NUM_OPS is rejected
    assign is_loadi   = (w_fields.op == c_OP_LOADI);
    assign is_illegal = !is_loadi && (32'(w_fields.op) >= NUM_OPS);

endmodule
`default_nettype wire

// File: rtl/rtype_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rtype_issue_ctrl
//  Description : Initiator-side controller for the R-type register-file/ALU
//                datapath. Accepts one instruction at a time, drives the
//                datapath fields through settle and write-back phases, and
//                returns the captured ALU result over a result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtype_issue_ctrl
    import rtype_pkg::*;
#(
    parameter int DW          = 32,
    parameter int RW          = 4,
    parameter int OPW         = 5,
    parameter int NUM_OPS     = 8,
    parameter int EXEC_CYCLES = 1,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [RW-1:0]   dp_rs,
    output logic [RW-1:0]   dp_rt,
    output logic [RW-1:0]   dp_rd,
    output logic [OPW-1:0]  dp_opcode,
    output logic [DW-1:0]   dp_data,
    output logic            dp_write,
    input  logic [DW-1:0]   dp_out,
    input  logic            dp_cout,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [DW-1:0]   res_data,
    output logic            res_cout,
    output logic [RW-1:0]   res_rd,
    output logic            res_err,
    output logic [CNTW-1:0] retired
);

    localparam int c_CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(EXEC_CYCLES - 1);

    rtype_state_e r_state;
    rtype_state_e w_state_nxt;

    logic               w_instr_ready;
    logic               w_res_valid;
    logic               w_dp_write;
    logic               w_capture;
    logic               w_accept;
    logic               w_retire;

    logic [OPW-1:0]     w_dec_op;
    logic [RW-1:0]      w_dec_rs;
    logic [RW-1:0]      w_dec_rt;
    logic [RW-1:0]      w_dec_rd;
    logic [DW-1:0]      w_dec_imm;
    logic               w_dec_loadi;
    logic               w_dec_illegal;

    logic [c_CNT_W-1:0] r_cnt;
    logic [RW-1:0]      r_rs;
    logic [RW-1:0]      r_rt;
    logic [RW-1:0]      r_rd;
    logic [OPW-1:0]     r_op;
    logic [DW-1:0]      r_data;
    logic               r_is_loadi;
    logic               r_is_illegal;
    logic [DW-1:0]      r_res_data;
    logic               r_res_cout;
    logic [RW-1:0]      r_res_rd;
    logic               r_res_err;
    logic [CNTW-1:0]    r_retired;

    rtype_instr_decode #(
        .DW      (DW),
        .NUM_OPS (NUM_OPS)
    ) u_decode (
        .instr      (instr),
        .op         (w_dec_op),
        .rs         (w_dec_rs),
        .rt         (w_dec_rt),
        .rd         (w_dec_rd),
        .imm_sext   (w_dec_imm),
        .is_loadi   (w_dec_loadi),
        .is_illegal (w_dec_illegal)
    );

    // State register; reset aborts any in-flight instruction immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state handshake / write-enable decode
    always_comb begin
        w_state_nxt   = r_state;
        w_instr_ready = 1'b0;
        w_res_valid   = 1'b0;
        w_dp_write    = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // Illegal opcodes keep the timing but never touch the regfile
                w_dp_write  = !r_is_illegal;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = w_instr_ready & instr_valid;
    assign w_retire = w_res_valid & res_ready;

    // Operand-settle counter, loaded on accept and run down in EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= c_CNT_LOAD;
        end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // Instruction fields held stable for the datapath from accept onward
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_op         <= '0;
            r_data       <= '0;
            r_is_loadi   <= 1'b0;
            r_is_illegal <= 1'b0;
        end else if (w_accept) begin
            r_rs         <= w_dec_rs;
            r_rt         <= w_dec_rt;
            r_rd         <= w_dec_rd;
            r_op         <= w_dec_op;
            r_data       <= w_dec_loadi ? w_dec_imm : '0;
            r_is_loadi   <= w_dec_loadi;
            r_is_illegal <= w_dec_illegal;
        end
    end

    // Result capture at the end of settle, before the write-back cycle, so
    // an rd that aliases rs/rt still yields the pre-write operand value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_data <= '0;
            r_res_cout <= 1'b0;
            r_res_rd   <= '0;
            r_res_err  <= 1'b0;
        end else if (w_capture) begin
            r_res_rd   <= r_rd;
            r_res_err  <= r_is_illegal;
            r_res_cout <= !r_is_illegal && !r_is_loadi && dp_cout;
            if (r_is_illegal) begin
                r_res_data <= '0;
            end else if (r_is_loadi) begin
                r_res_data <= r_data;
            end else begin
                r_res_data <= dp_out;
            end
        end
    end

    // Retired-instruction counter; wraps naturally at its width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNTW'(1);
        end
    end

    assign instr_ready = w_instr_ready;
    assign dp_rs       = r_rs;
    assign dp_rt       = r_rt;
    assign dp_rd       = r_rd;
    assign dp_opcode   = r_op;
    assign dp_data     = r_data;
    assign dp_write    = w_dp_write;
    assign res_valid   = w_res_valid;
    assign res_data    = r_res_data;
    assign res_cout    = r_res_cout;
    assign res_rd      = r_res_rd;
    assign res_err     = r_res_err;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_rtype_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtype_issue_ctrl
//  Description : Self-checking bench for rtype_issue_ctrl with a behavioural
//                register-file/ALU datapath and an instruction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtype_issue_ctrl;

    localparam int DW      = 32;
    localparam int RW      = 4;
    localparam int OPW     = 5;
    localparam int NUM_OPS = 8;
    localparam int E       = 2;
    localparam int CNTW    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic [RW-1:0]   dp_rs;
    logic [RW-1:0]   dp_rt;
    logic [RW-1:0]   dp_rd;
    logic [OPW-1:0]  dp_opcode;
    logic [DW-1:0]   dp_data;
    logic            dp_write;
    logic [DW-1:0]   dp_out;
    logic            dp_cout;
    logic            res_valid;
    logic            res_ready;
    logic [DW-1:0]   res_data;
    logic            res_cout;
    logic [RW-1:0]   res_rd;
    logic            res_err;
    logic [CNTW-1:0] retired;

    int n_vec  = 0;
    int n_fail = 0;
    int ref_retired = 0;
    int wr_edges = 0;
    time t_accept;
    logic tb_init;
    logic [31:0] ref_regs [16];
    logic [31:0] dp_regs  [16];
    logic [32:0] dp_alu;

    always #5 clk = ~clk;

    rtype_issue_ctrl #(
        .DW(DW), .RW(RW), .OPW(OPW), .NUM_OPS(NUM_OPS),
        .EXEC_CYCLES(E), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .dp_rs(dp_rs), .dp_rt(dp_rt), .dp_rd(dp_rd), .dp_opcode(dp_opcode),
        .dp_data(dp_data), .dp_write(dp_write), .dp_out(dp_out), .dp_cout(dp_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_rd(res_rd), .res_err(res_err), .retired(retired)
    );

    // ALU semantics: {carry, result}
    function automatic logic [32:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:    alu = {1'b0, a} + {1'b0, b};
            5'd1:    alu = {1'b0, a} - {1'b0, b};
            5'd2:    alu = {1'b0, a & b};
            5'd3:    alu = {1'b0, a | b};
            5'd4:    alu = {1'b0, a ^ b};
            default: alu = {1'b0, a};
        endcase
    endfunction

    function automatic logic [31:0] seed(input int i);
        seed = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rs, input logic [3:0] rt,
                                       input logic [3:0] rd, input logic [14:0] imm);
        mk = {op, rs, rt, rd, imm};
    endfunction

    // Datapath: combinational ALU over the register file, write on dp_write
    always_comb dp_alu = alu(dp_opcode, dp_regs[dp_rs], dp_regs[dp_rt]);
    assign dp_out  = dp_alu[31:0];
    assign dp_cout = dp_alu[32];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 16; i++) dp_regs[i] <= seed(i);
        end else if (dp_write) begin
            dp_regs[dp_rd] <= (dp_opcode == 5'h1F) ? dp_data : dp_out;
        end
    end

    always @(posedge clk) if (dp_write === 1'b1) wr_edges <= wr_edges + 1;

    // Full instruction transaction against the reference model; called at a negedge
    task automatic run_instr(input logic [31:0] w, input int hold, input string tag);
        logic [4:0]  op;
        logic [3:0]  rs, rt, rd;
        logic [14:0] imm;
        logic [31:0] e_data, e_dpdata;
        logic        e_cout, e_err;
        logic [32:0] r;
        int          e_wr, k, writes;
        bit          seen;
        op = w[31:27]; rs = w[26:23]; rt = w[22:19]; rd = w[18:15]; imm = w[14:0];
        e_dpdata = '0;
        if (op == 5'h1F) begin
            e_data = {{17{imm[14]}}, imm}; e_dpdata = e_data; e_cout = 1'b0; e_err = 1'b0; e_wr = 1;
        end else if (int'(op) >= NUM_OPS) begin
            e_data = '0; e_cout = 1'b0; e_err = 1'b1; e_wr = 0;
        end else begin
            r = alu(op, ref_regs[rs], ref_regs[rt]);
            e_data = r[31:0]; e_cout = r[32]; e_err = 1'b0; e_wr = 1;
        end
        n_vec++;
        if (instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s accept_ready: got %b want 1", tag, instr_ready);
        end
        instr = w; instr_valid = 1'b1; res_ready = (hold == 0);
        @(posedge clk); t_accept = $time;
        @(negedge clk); instr_valid = 1'b0; instr = $urandom;
        k = 1; writes = 0; seen = 0;
        while (!seen && k <= 40) begin
            if (res_valid === 1'b1) begin
                seen = 1;
            end else begin
                n_vec++;
                if ({instr_ready, dp_rs, dp_rt, dp_rd, dp_opcode, dp_data} !== {1'b0, rs, rt, rd, op, e_dpdata}) begin
                    n_fail++;
                    $display("FAIL %s busy_fields cyc%0d: got rdy=%b rs=%0d rt=%0d rd=%0d op=%0d data=%h want rdy=0 rs=%0d rt=%0d rd=%0d op=%0d data=%h",
                             tag, k, instr_ready, dp_rs, dp_rt, dp_rd, dp_opcode, dp_data, rs, rt, rd, op, e_dpdata);
                end
                if (dp_write === 1'b1) begin
                    writes++;
                    n_vec++;
                    if (k != E + 1) begin
                        n_fail++; $display("FAIL %s write_cycle: got %0d want %0d", tag, k, E + 1);
                    end
                end
                k++;
                @(negedge clk);
            end
        end
        n_vec++;
        if (!seen || k != E + 2) begin
            n_fail++; $display("FAIL %s latency: got %0d (seen=%0d) want %0d", tag, k, seen, E + 2);
        end
        n_vec++;
        if ({res_data, res_cout, res_rd, res_err} !== {e_data, e_cout, rd, e_err}) begin
            n_fail++;
            $display("FAIL %s result: got data=%h cout=%b rd=%0d err=%b want data=%h cout=%b rd=%0d err=%b",
                     tag, res_data, res_cout, res_rd, res_err, e_data, e_cout, rd, e_err);
        end
        n_vec++;
        if (writes != e_wr) begin
            n_fail++; $display("FAIL %s write_count: got %0d want %0d", tag, writes, e_wr);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_vec++;
            if ({res_valid, instr_ready, dp_write, res_data, res_cout, res_rd, res_err} !== {3'b100, e_data, e_cout, rd, e_err}) begin
                n_fail++;
                $display("FAIL %s stall_hold%0d: got v=%b rdy=%b wr=%b data=%h want v=1 rdy=0 wr=0 data=%h",
                         tag, i, res_valid, instr_ready, dp_write, res_data, e_data);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        ref_retired++;
        if (e_wr != 0) ref_regs[rd] = e_data;
        n_vec++;
        if (res_valid !== 1'b0 || retired !== CNTW'(ref_retired)) begin
            n_fail++;
            $display("FAIL %s retire: got v=%b retired=%0d want v=0 retired=%0d", tag, res_valid, retired, CNTW'(ref_retired));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tb_init = 1'b1; instr_valid = 1'b0; res_ready = 1'b0; instr = '0;
        for (int i = 0; i < 16; i++) ref_regs[i] = seed(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; tb_init = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({dp_rs, dp_rt, dp_rd, dp_opcode, dp_data, dp_write} !== '0) begin
            n_fail++; $display("FAIL reset_dp: got rs=%0d rt=%0d rd=%0d op=%0d data=%h wr=%b want all 0",
                               dp_rs, dp_rt, dp_rd, dp_opcode, dp_data, dp_write);
        end
        n_vec++;
        if ({res_valid, res_data, res_cout, res_rd, res_err} !== '0) begin
            n_fail++; $display("FAIL reset_res: got v=%b data=%h cout=%b rd=%0d err=%b want all 0",
                               res_valid, res_data, res_cout, res_rd, res_err);
        end
        n_vec++;
        if (retired !== '0 || instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ctrl: got retired=%0d ready=%b want 0/1", retired, instr_ready);
        end
    endtask

    task automatic test_reset_mid_exec();
        int w0;
        instr = mk(5'd0, 4'd1, 4'd2, 4'd9, 15'd0); instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        n_vec++;
        if (dp_rd !== 4'd9 || instr_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_inflight: got rd=%0d ready=%b want 9/0", dp_rd, instr_ready);
        end
        w0 = wr_edges;
        reset = 1'b1;
        #1;
        n_vec++;
        if (dp_write !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_async: got wr=%b v=%b want 0/0", dp_write, res_valid);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (wr_edges != w0 || instr_ready !== 1'b1 || res_valid !== 1'b0 || retired !== '0 || dp_rd !== '0) begin
            n_fail++; $display("FAIL abort_after: got writes=%0d ready=%b v=%b retired=%0d rd=%0d want %0d/1/0/0/0",
                               wr_edges, instr_ready, res_valid, retired, dp_rd, w0);
        end
    endtask

    task automatic test_loadi();
        run_instr(32'hF800_8005, 0, "loadi_r1");
        n_vec++;
        if (res_data !== 32'd5 || res_rd !== 4'd1 || res_err !== 1'b0) begin
            n_fail++; $display("FAIL loadi_r1_value: got data=%h rd=%0d err=%b want 5/1/0", res_data, res_rd, res_err);
        end
        run_instr(32'hF801_0007, 0, "loadi_r2");
        run_instr(mk(5'h1F, 4'd3, 4'd4, 4'd5, 15'h7FFF), 0, "loadi_neg");
        n_vec++;
        if (res_data !== 32'hFFFF_FFFF || res_cout !== 1'b0) begin
            n_fail++; $display("FAIL loadi_sext: got data=%h cout=%b want ffffffff/0", res_data, res_cout);
        end
        run_instr(mk(5'h1F, 4'd0, 4'd0, 4'd6, 15'd1), 0, "loadi_one");
    endtask

    task automatic test_add();
        int r0;
        r0 = ref_retired;
        run_instr(32'h0091_8000, 0, "add_r3");
        n_vec++;
        if (res_data !== 32'd12 || res_cout !== 1'b0 || res_rd !== 4'd3 || retired !== CNTW'(r0 + 1)) begin
            n_fail++; $display("FAIL add_value: got data=%0d cout=%b rd=%0d retired=%0d want 12/0/3/%0d",
                               res_data, res_cout, res_rd, retired, CNTW'(r0 + 1));
        end
    endtask

    task automatic test_carry();
        run_instr(mk(5'd0, 4'd5, 4'd6, 4'd7, 15'd0), 0, "add_carry");
        n_vec++;
        if (res_data !== 32'd0 || res_cout !== 1'b1) begin
            n_fail++; $display("FAIL carry_value: got data=%h cout=%b want 0/1", res_data, res_cout);
        end
    endtask

    task automatic test_backpressure();
        run_instr(mk(5'd1, 4'd3, 4'd1, 4'd8, 15'd0), 5, "stall");
        run_instr(mk(5'd4, 4'd8, 4'd8, 4'd8, 15'd0), 3, "stall_alias");
    endtask

    task automatic test_illegal();
        run_instr(32'h4000_0000, 0, "illegal_op8");
        n_vec++;
        if (res_err !== 1'b1 || res_data !== 32'd0 || res_cout !== 1'b0) begin
            n_fail++; $display("FAIL illegal_value: got err=%b data=%h cout=%b want 1/0/0", res_err, res_data, res_cout);
        end
        run_instr(mk(5'd30, 4'd5, 4'd6, 4'd1, 15'h1234), 1, "illegal_op30");
    endtask

    task automatic test_back_to_back();
        time t_prev;
        run_instr(mk(5'd0, 4'd1, 4'd1, 4'd10, 15'd0), 0, "b2b_0");
        for (int i = 1; i < 4; i++) begin
            t_prev = t_accept;
            run_instr(mk(5'd0, 4'd10, 4'd1, 4'd10, 15'd0), 0, "b2b");
            n_vec++;
            if (t_accept - t_prev != time'((E + 3) * 10)) begin
                n_fail++; $display("FAIL b2b_interval: got %0t want %0d", t_accept - t_prev, (E + 3) * 10);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] op;
        int sel;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      op = 5'($urandom_range(0, NUM_OPS - 1));
            else if (sel < 8) op = 5'h1F;
            else              op = 5'($urandom_range(NUM_OPS, 30));
            run_instr(mk(op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)),
                      $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_loadi();
        test_add();
        test_carry();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/rtype_issue_ctrl.md
Name: rtype_issue_ctrl

Overview:
Initiator-side controller for the R-type register-file/ALU datapath. It accepts packed 32-bit R-type instruction words over a valid/ready handshake and decodes them into the datapath fields `rs`/`rt`/`rd`/`opcode`/`data`/`write`. It sequences each instruction through operand-settle and write-back phases, then captures the ALU result and carry and returns them over a valid/ready result handshake. It sits between instruction fetch and the datapath and replaces hand-driven stimulus.

Parameters:
DW, 32, datapath data width
RW, 4, register address width (instruction encoding fixed for RW=4)
OPW, 5, opcode width
NUM_OPS, 8, legal ALU opcodes are 0..NUM_OPS-1
EXEC_CYCLES, 1, operand-settle cycles before the result is sampled (>=1)
CNTW, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction word valid
instr  in  32  [31:27] op, [26:23] rs, [22:19] rt, [18:15] rd, [14:0] imm
instr_ready  out  1  controller can accept an instruction
dp_rs  out  RW  datapath read address 1
dp_rt  out  RW  datapath read address 2
dp_rd  out  RW  datapath write address
dp_opcode  out  OPW  datapath opcode
dp_data  out  DW  immediate write data (LOADI only, else 0)
dp_write  out  1  datapath register write enable
dp_out  in  DW  datapath ALU result (combinational from current fields)
dp_cout  in  1  datapath carry out
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  DW  captured result
res_cout  out  1  captured carry
res_rd  out  RW  destination register of the result
res_err  out  1  instruction had an illegal opcode
retired  out  CNTW  count of completed instructions

Behaviour:
- Reset (async): state IDLE; all dp_* = 0; res_* = 0; retired = 0; instr_ready = 1 once reset is released.
- States: IDLE, EXEC, COMMIT, RESP.
- IDLE: instr_ready=1. On instr_valid&instr_ready, register all fields, load the settle counter with EXEC_CYCLES-1, then go to EXEC.
- EXEC: drive dp_rs/rt/rd/opcode from the registered fields; dp_write=0. Count down the settle counter. When it reaches 0, sample dp_out/dp_cout into res_data/res_cout and go to COMMIT.
- COMMIT: dp_write=1 for exactly one cycle with fields unchanged, then go to RESP.
- RESP: res_valid=1; res_* held stable. On res_ready, increment retired and go to IDLE. res_valid drops the next cycle.
- LOADI (op=5'h1F): dp_data = sign-extended imm[14:0]; dp_write is asserted in COMMIT; res_data = dp_data (dp_out is ignored); res_cout=0.
- Illegal opcode (NUM_OPS <= op < 31):
  - dp_write is never asserted.
  - res_err=1, res_data=0, res_cout=0.
  - The instruction still passes through EXEC/COMMIT timing and is counted in retired.
- Latency: accept at edge T, res_valid high after edge T+EXEC_CYCLES+2. Minimum issue interval is EXEC_CYCLES+3 cycles with res_ready held high.
- instr_ready=0 in every state except IDLE. A new instruction is never overlapped with an outstanding result.
- dp_write is asserted only in COMMIT; at most one pulse per instruction.
- retired wraps modulo 2^CNTW.
- Reset mid-operation: abort immediately; no dp_write is issued afterwards; the in-flight instruction is lost and not counted.
- Write to rd equal to rs or rt is legal: the datapath reads the old value because the result is sampled before COMMIT.

Decomposition:
- Shared package `rtype_pkg`:
  - instruction field bit positions
  - LOADI opcode constant
  - state encoding typedef
  - `rtype_instr_t` struct
- Natural sub-module `rtype_instr_decode`: purely combinational; instr -> fields, sign-extended immediate, is_loadi, is_illegal. The FSM, counters and result registers stay in the top module.

Test Plan:
1. Hold reset 2 cycles then release -> all dp_* = 0, res_valid=0, retired=0, instr_ready=1.
2. LOADI r1=5, instr=0xF800_8005 accepted at T -> dp_rd=1, dp_data=5, dp_write=1 only in cycle T+2; res_valid at T+3 with res_data=5, res_rd=1, res_err=0.
3. Bench datapath model with op0 = add, r1=5, r2=7. Issue instr=0x0091_8000 (add r3=r1+r2) -> dp_rs=1, dp_rt=2 during EXEC; res_data=12, res_cout=0; single dp_write with dp_rd=3; retired=1.
4. Add 0xFFFF_FFFF+1 via the model -> res_data=0, res_cout=1.
5. res_ready held low 5 cycles in RESP -> res_valid and res_* stable, instr_ready=0, no extra dp_write; retired increments by exactly 1 on release.
6. Illegal op 8, instr=0x4000_0000 -> no dp_write, res_err=1, res_data=0. Separately, assert reset during EXEC -> dp_write never pulses, state returns to IDLE, retired unchanged.
